// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of the async FIFO write
// port (winc/wdata/wfull) between NREQ requesters, entirely in the wclk domain.
// A grant lasts up to BURST accepted words; wfull stalls the owner word by word.
// Optional build macro FIFO_WR_ARB_PRIO0_EN: requester 0 gets fixed-highest
// priority, alternating with the round-robin choice among requesters 1..NREQ-1
// so those are never starved. Requester 0's bursts are still BURST-bounded.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 16,
  parameter int BURST = 8
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata
);

  localparam int LW  = $clog2(NREQ);
  localparam int LW1 = LW + 1;
  localparam int CW  = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

`ifdef FIFO_WR_ARB_PRIO0_EN
  localparam bit SKIP0 = 1'b1;
`else
  localparam bit SKIP0 = 1'b0;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [LW-1:0]   owner_q, owner_d;
  logic [LW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [LW-1:0]   rr_sel;
  logic            rr_found;
  logic [LW-1:0]   sel;
  logic            go;
  logic            upd_last;
  logic            owner_req;

  // Round-robin scan: first asserted req after last, wrapping modulo NREQ.
  always_comb begin : rr_scan
    logic [LW1-1:0] idx;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    rr_sel   = '0;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW1'(last_q) + LW1'(k);
      if (idx >= LW1'(NREQ)) idx = idx - LW1'(NREQ);
      if (!rr_found && req[idx[LW-1:0]] && !(SKIP0 && idx == '0)) begin
        rr_sel   = idx[LW-1:0];
        rr_found = 1'b1;
      end
    end
  end

`ifdef FIFO_WR_ARB_PRIO0_EN
  logic prev0_q, prev0_d;

  // Requester 0 wins unless it owned the previous grant and someone else waits.
  always_comb begin
    go       = |req;
    sel      = rr_sel;
    upd_last = 1'b1;
    if (req[0] && (!prev0_q || !rr_found)) begin
      sel      = '0;
      upd_last = 1'b0;
    end
  end

  // Remembers whether the most recent grant went to requester 0.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) prev0_q <= 1'b0;
    else         prev0_q <= prev0_d;
  end

  // prev0 only changes when a new grant is issued from IDLE.
  always_comb begin
    prev0_d = prev0_q;
    if (state_q == S_IDLE && go) prev0_d = (sel == '0);
  end
`else
  assign go       = rr_found;
  assign sel      = rr_sel;
  assign upd_last = 1'b1;
`endif

  // Write-port outputs: winc follows the owner's req and wfull combinationally.
  always_comb begin
    owner_req = req[owner_q];
    busy      = (state_q == S_BURST);
    winc      = busy && owner_req && !wfull;
    ack       = grant_q & {NREQ{winc}};
    wdata     = busy ? req_data[owner_q*DSIZE +: DSIZE] : '0;
  end

  assign grant = grant_q;

  // Next-state logic: arbitrate in IDLE, count and watch for exit in BURST.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_BURST;
          grant_d = NREQ'(1) << sel;
          owner_d = sel;
          cnt_d   = '0;
          if (upd_last) last_d = sel;
        end
      end
      S_BURST: begin
        if (winc) cnt_d = cnt_q + CW'(1);
        // Exit on the last word of the burst, or as soon as the owner lets go.
        if ((winc && cnt_q == CNT_LAST) || !owner_req) begin
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any burst and points last at NREQ-1.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requester models feed counting words, a
// scoreboard of expected (ack, wdata) pairs is filled when stimulus is set up
// and drained by a negedge monitor on every winc.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 16;
  localparam int BURST = 8;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .grant    (grant),
    .busy     (busy),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata)
  );

  typedef struct packed {
    logic [NREQ-1:0]  ack;
    logic [DSIZE-1:0] word;
  } exp_t;

  exp_t            sb[$];
  logic [NREQ-1:0] grant_log[$];
  logic [NREQ-1:0] prev_grant = '0;
  logic [NREQ-1:0] ack_seen   = '0;
  int              checks     = 0;
  int              failures   = 0;
  int              writes     = 0;
  int              rem[NREQ];
  logic [7:0]      seq[NREQ];
  logic [7:0]      pushed[NREQ];

  function automatic logic [DSIZE-1:0] word_of(int id, logic [7:0] s);
    return {8'(id), s};
  endfunction

  // Drive req/req_data from the requester model state.
  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (rem[i] > 0);
      req_data[i*DSIZE +: DSIZE] = word_of(i, seq[i]);
    end
  endtask

  task automatic push_burst(int id, int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ack  = NREQ'(1) << id;
      e.word = word_of(id, pushed[id]);
      sb.push_back(e);
      pushed[id] = pushed[id] + 8'd1;
    end
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (sb.size() == 0) && (grant == '0) && !busy;
    for (int i = 0; i < NREQ; i++) if (rem[i] != 0) q = 0;
    return q;
  endfunction

  function automatic logic [31:0] packed_log();
    logic [31:0] v;
    v = '0;
    foreach (grant_log[i]) v = {v[27:0], grant_log[i]};
    return v;
  endfunction

  // Requester model: an acked word advances to the next one after the edge.
  initial begin
    forever begin
      @(posedge wclk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack_seen[i]) begin
          seq[i] = seq[i] + 8'd1;
          if (rem[i] > 0) rem[i] = rem[i] - 1;
        end
      end
      ack_seen = '0;
      apply();
    end
  end

  // Monitor: scoreboard compare on each write, plus per-cycle invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      ack_seen = ack;
      if (grant != '0 && grant != prev_grant) grant_log.push_back(grant);
      prev_grant = grant;
      if (winc) begin
        writes++;
        checks++;
        if (wfull) begin
          failures++;
          $display("FAIL winc_while_full winc=%b wfull=%b", winc, wfull);
        end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write ack=%b wdata=%h, no write expected", ack, wdata);
        end else begin
          e = sb.pop_front();
          if (ack !== e.ack || wdata !== e.word) begin
            failures++;
            $display("FAIL write_data got ack=%b wdata=%h need ack=%b wdata=%h",
                     ack, wdata, e.ack, e.word);
          end
        end
      end else if (busy) begin
        checks++;
        if (ack !== '0) begin
          failures++;
          $display("FAIL ack_without_winc got ack=%b need 0000", ack);
        end
      end
    end
  end

  task automatic wait_drained(int budget, string name);
    int n = 0;
    while (!all_quiet() && n < budget) begin
      @(negedge wclk);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_drain_timeout got %0d pending words need 0 after %0d cycles",
               name, sb.size(), budget);
    end
  endtask

  task automatic wait_writes(int target, int budget, string name);
    int n = 0;
    while (writes < target && n < budget) begin
      @(negedge wclk);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_write_timeout got %0d writes need %0d", name, writes, target);
    end
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; seq[i] = 8'(16 * i); pushed[i] = 8'(16 * i);
    end
    apply();
    #12;
    checks++;
    if ({grant, busy, winc, ack, wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got grant=%b busy=%b winc=%b ack=%b wdata=%h need all 0",
               grant, busy, winc, ack, wdata);
    end
    @(posedge wclk);
    #2;
    wrst_n = 1'b1;
    @(negedge wclk);
    checks++;
    if ({grant, busy, winc, ack, wdata} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got grant=%b busy=%b winc=%b ack=%b wdata=%h need all 0",
               grant, busy, winc, ack, wdata);
    end
  endtask

  task automatic test_round_robin();
    int base;
    logic [31:0] got;
    @(posedge wclk);
    #2;
    grant_log.delete();
    base = writes;
    rem[0] = 24; rem[1] = 8; rem[2] = 8; rem[3] = 8;
`ifdef FIFO_WR_ARB_PRIO0_EN
    push_burst(0, 8); push_burst(1, 8); push_burst(0, 8);
    push_burst(2, 8); push_burst(0, 8); push_burst(3, 8);
`else
    push_burst(0, 8); push_burst(1, 8); push_burst(2, 8);
    push_burst(3, 8); push_burst(0, 8); push_burst(0, 8);
`endif
    apply();
    wait_drained(600, "round_robin");
    got = packed_log();
    checks++;
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (grant_log.size() != 6 || got !== 32'h0012_1418) begin
`else
    if (grant_log.size() != 6 || got !== 32'h0012_4811) begin
`endif
      failures++;
      $display("FAIL rr_grant_order got %0d grants %h", grant_log.size(), got);
    end
    checks++;
    if (writes - base != 48) begin
      failures++;
      $display("FAIL rr_write_total got %0d need 48", writes - base);
    end
  endtask

  task automatic test_single();
    int n = 1;
    int guard = 0;
    @(posedge wclk);
    #2;
    rem[1] = 16;
    push_burst(1, 16);
    apply();
    @(negedge wclk);
    checks++;
    if (grant !== '0 || winc !== 1'b0) begin
      failures++;
      $display("FAIL single_arb_cycle got grant=%b winc=%b need 0000 0", grant, winc);
    end
    @(negedge wclk);
    checks++;
    if (grant !== 4'b0010 || !busy || !winc || ack !== 4'b0010) begin
      failures++;
      $display("FAIL single_first_write got grant=%b busy=%b winc=%b ack=%b need 0010 1 1 0010",
               grant, busy, winc, ack);
    end
    while (grant != '0 && guard < 50) begin
      @(negedge wclk);
      if (grant != '0 && winc) n++;
      guard++;
    end
    checks++;
    if (n != BURST) begin
      failures++;
      $display("FAIL single_burst_len got %0d need %0d", n, BURST);
    end
    checks++;
    if (grant !== '0 || winc !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_bubble got grant=%b winc=%b busy=%b need 0000 0 0", grant, winc, busy);
    end
    @(negedge wclk);
    checks++;
    if (grant !== 4'b0010 || !winc) begin
      failures++;
      $display("FAIL single_regrant got grant=%b winc=%b need 0010 1", grant, winc);
    end
    wait_drained(100, "single");
  endtask

  task automatic test_back_pressure();
    int base;
    @(posedge wclk);
    #2;
    base = writes;
    rem[2] = 8;
    push_burst(2, 8);
    apply();
    wait_writes(base + 3, 50, "bp");
    @(posedge wclk);
    #2;
    wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk);
      checks++;
      if (winc !== 1'b0 || ack !== '0 || grant !== 4'b0100 || !busy) begin
        failures++;
        $display("FAIL bp_stall_%0d got winc=%b ack=%b grant=%b busy=%b need 0 0000 0100 1",
                 c, winc, ack, grant, busy);
      end
    end
    @(posedge wclk);
    #2;
    wfull = 1'b0;
    wait_drained(100, "bp");
    checks++;
    if (writes - base != 8) begin
      failures++;
      $display("FAIL bp_write_total got %0d need 8", writes - base);
    end
  endtask

  task automatic test_early_release();
    int base;
    int n = 0;
    logic [31:0] got;
    @(posedge wclk);
    #2;
    base = writes;
    grant_log.delete();
    rem[3] = 3;
    rem[0] = 8;
`ifdef FIFO_WR_ARB_PRIO0_EN
    push_burst(0, 8); push_burst(3, 3);
`else
    push_burst(3, 3); push_burst(0, 8);
`endif
    apply();
    while (rem[3] != 0 && n < 100) begin
      @(posedge wclk);
      #2;
      n++;
    end
    @(negedge wclk);
    checks++;
    if (grant !== 4'b1000 || !busy || winc !== 1'b0) begin
      failures++;
      $display("FAIL er_release_cycle got grant=%b busy=%b winc=%b need 1000 1 0", grant, busy, winc);
    end
    @(negedge wclk);
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL er_idle got grant=%b busy=%b need 0000 0", grant, busy);
    end
    wait_drained(100, "er");
    got = packed_log();
    checks++;
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (grant_log.size() != 2 || got !== 32'h18) begin
`else
    if (grant_log.size() != 2 || got !== 32'h81) begin
`endif
      failures++;
      $display("FAIL er_grant_order got %0d grants %h", grant_log.size(), got);
    end
    checks++;
    if (writes - base != 11) begin
      failures++;
      $display("FAIL er_write_total got %0d need 11", writes - base);
    end
  endtask

  task automatic test_reset_mid_burst();
    int base;
    logic [31:0] got;
    @(posedge wclk);
    #2;
    base = writes;
    rem[1] = 8;
    push_burst(1, 8);
    apply();
    wait_writes(base + 3, 50, "rst");
    @(posedge wclk);
    #2;
    checks++;
    if (winc !== 1'b1 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL rst_fourth_write got winc=%b grant=%b need 1 0010", winc, grant);
    end
    wrst_n = 1'b0;
    #1;
    checks++;
    if ({grant, winc, ack, busy} !== '0) begin
      failures++;
      $display("FAIL rst_async got grant=%b winc=%b ack=%b busy=%b need all 0",
               grant, winc, ack, busy);
    end
    sb.delete();
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; pushed[i] = seq[i];
    end
    rem[0] = 8;
    rem[1] = 8;
    push_burst(0, 8);
    push_burst(1, 8);
    apply();
    @(posedge wclk);
    #2;
    checks++;
    if ({grant, winc, busy} !== '0) begin
      failures++;
      $display("FAIL rst_hold got grant=%b winc=%b busy=%b need all 0", grant, winc, busy);
    end
    wrst_n = 1'b1;
    wait_drained(100, "rst");
    got = packed_log();
    checks++;
    if (grant_log.size() != 2 || got !== 32'h12) begin
      failures++;
      $display("FAIL rst_grant_order got %0d grants %h need 2 grants 12", grant_log.size(), got);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_back_pressure();
    test_early_release();
    test_reset_mid_burst();
    repeat (2) @(negedge wclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
